// File: rtl/regfile_pkg.sv
// Shared constants for the Y86 register file: widths, register IDs and register count.
package regfile_pkg;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [BYTE_W-1:0] REAX  = 8'h0;
  localparam logic [BYTE_W-1:0] RESP  = 8'h4;
  localparam logic [BYTE_W-1:0] RNONE = 8'hF;
endpackage

// File: rtl/regfile_rd.sv
// Register-file read mux: selects one register by ID, returning zero for IDs outside 0..7.
module regfile_rd
  import regfile_pkg::*;
(
  input  logic [BYTE_W-1:0]            id_i,
  input  logic [NREGS-1:0][WORD_W-1:0] regs_i,
  output logic [WORD_W-1:0]            val_o
);

  logic id_valid;

  assign id_valid = (id_i[BYTE_W-1:IDX_W] == '0);
  assign val_o    = id_valid ? regs_i[id_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/regfile.sv
// Y86 architectural register file: two combinational decode read ports, a debug read port,
// two clocked write-back ports (valM wins on collision) and a committed-write counter.
module regfile
  import regfile_pkg::*;
#(
  parameter logic [31:0] RESET_ESP = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        d_srcA_i,
  input  logic [7:0]        d_srcB_i,
  output logic [31:0]       d_rvalA_o,
  output logic [31:0]       d_rvalB_o,
  input  logic [7:0]        W_dstE_i,
  input  logic [31:0]       W_valE_i,
  input  logic [7:0]        W_dstM_i,
  input  logic [31:0]       W_valM_i,
  input  logic [2:0]        dbg_id_i,
  output logic [31:0]       dbg_val_o,
  output logic [31:0]       wr_count_o
);

  logic [NREGS-1:0][WORD_W-1:0] regs_q, regs_d;
  logic [WORD_W-1:0]            cnt_q, cnt_d;
  logic                         e_vld, m_vld;
  logic [1:0]                   n_writes;

  assign e_vld = (W_dstE_i[BYTE_W-1:IDX_W] == '0);
  assign m_vld = (W_dstM_i[BYTE_W-1:IDX_W] == '0);

  // Next register state; the M write is applied last so it overrides E on a collision.
  always_comb begin
    regs_d   = regs_q;
    n_writes = 2'd0;
    if (e_vld) begin
      regs_d[W_dstE_i[IDX_W-1:0]] = W_valE_i;
    end
    if (m_vld) begin
      regs_d[W_dstM_i[IDX_W-1:0]] = W_valM_i;
    end
    if (e_vld && m_vld) begin
      n_writes = (W_dstE_i == W_dstM_i) ? 2'd1 : 2'd2;
    end else if (e_vld || m_vld) begin
      n_writes = 2'd1;
    end
    cnt_d = cnt_q + WORD_W'(n_writes);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q                     <= '0;
      regs_q[RESP[IDX_W-1:0]]    <= RESET_ESP;
      cnt_q                      <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  regfile_rd u_rd_a (
    .id_i   (d_srcA_i),
    .regs_i (regs_q),
    .val_o  (d_rvalA_o)
  );

  regfile_rd u_rd_b (
    .id_i   (d_srcB_i),
    .regs_i (regs_q),
    .val_o  (d_rvalB_o)
  );

  regfile_rd u_rd_dbg (
    .id_i   ({5'b0, dbg_id_i}),
    .regs_i (regs_q),
    .val_o  (dbg_val_o)
  );

  assign wr_count_o = cnt_q;

endmodule
